// File: rtl/sm4_pkg.sv
// sm4_pkg: shared sequencer states, sizing defaults and round-key type for the SM4 controller.
package sm4_pkg;
   localparam int ROUNDS     = 32;
   localparam int AW         = 5;
   localparam int KX_TIMEOUT = 64;
   localparam int TW         = $clog2(KX_TIMEOUT);
   typedef logic [31:0] rk_t;
   typedef enum logic [2:0] {S_IDLE, S_KEXP, S_KFIN, S_LOAD, S_ROUND, S_DONE} state_t;
endpackage

// File: rtl/sm4_key_store.sv
// sm4_key_store: 32x32 round-key file, sync write from the expander, registered read toward the rounds.
module sm4_key_store
   import sm4_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  rk_t           i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output rk_t           o_rdata
);
   rk_t r_mem [ROUNDS];
   always_ff @(posedge i_clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/sm4_ctrl.sv
// sm4_ctrl: SM4 top-level sequencer; runs key expansion into a local store, then 32-round
// encrypt/decrypt passes feeding one round key per cycle.
module sm4_ctrl
   import sm4_pkg::*;
(
   input  logic          sm4_ctrl_clk,
   input  logic          sm4_ctrl_rst,
   input  logic          key_req,
   output logic          key_ok,
   output logic          key_err,
   output logic          kx_begin,
   output logic          kx_hs,
   output logic          kx_last,
   input  logic          kx_en,
   input  logic [AW-1:0] kx_addr,
   input  logic [31:0]   kx_rk,
   input  logic          kx_complete,
   input  logic          blk_valid,
   input  logic          blk_dec,
   output logic          blk_ready,
   output logic          rnd_start,
   output logic          rnd_en,
   output logic [AW-1:0] rnd_idx,
   output logic [31:0]   rnd_key,
   output logic          done_valid,
   input  logic          done_ready
);
   state_t        r_state, w_next;
   logic          r_pend, r_dec;
   logic [TW-1:0] r_tmo;
   logic          w_req, w_accept, w_timeout, w_busy;
   logic [AW-1:0] w_idx1, w_fwd, w_raddr;

   assign w_req     = key_req | r_pend;
   assign blk_ready = (r_state == S_IDLE) & key_ok & ~key_req & ~r_pend;
   assign w_accept  = blk_valid & blk_ready;
   assign w_timeout = r_tmo == TW'(KX_TIMEOUT - 1);
   assign w_busy    = r_state inside {S_LOAD, S_ROUND, S_DONE};
   assign w_idx1    = rnd_idx + 1'b1;
   // reverse order is the bitwise complement because ROUNDS == 2**AW
   assign w_fwd     = (r_state == S_LOAD) ? '0 : w_idx1;
   assign w_raddr   = r_dec ? ~w_fwd : w_fwd;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = w_req ? S_KEXP : w_accept ? S_LOAD : S_IDLE;
         S_KEXP:  w_next = (kx_complete | w_timeout) ? S_KFIN : S_KEXP;
         S_KFIN:  w_next = S_IDLE;
         S_LOAD:  w_next = S_ROUND;
         S_ROUND: w_next = (rnd_idx == AW'(ROUNDS - 1)) ? S_DONE : S_ROUND;
         S_DONE:  w_next = done_ready ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sm4_ctrl_clk or posedge sm4_ctrl_rst) begin
      if (sm4_ctrl_rst) begin
         r_state    <= S_IDLE;
         r_pend     <= 1'b0;
         r_dec      <= 1'b0;
         r_tmo      <= '0;
         key_ok     <= 1'b0;
         key_err    <= 1'b0;
         kx_begin   <= 1'b0;
         kx_hs      <= 1'b0;
         kx_last    <= 1'b0;
         rnd_start  <= 1'b0;
         rnd_en     <= 1'b0;
         rnd_idx    <= '0;
         done_valid <= 1'b0;
      end else begin
         r_state    <= w_next;
         kx_begin   <= w_next == S_KEXP;
         kx_hs      <= w_next == S_KEXP;
         kx_last    <= w_next == S_KFIN;
         rnd_start  <= w_next == S_LOAD;
         rnd_en     <= w_next == S_ROUND;
         done_valid <= w_next == S_DONE;
         rnd_idx    <= (r_state == S_ROUND && w_next == S_ROUND) ? w_idx1 : '0;
         r_tmo      <= (r_state == S_KEXP) ? r_tmo + 1'b1 : '0;
         r_pend     <= (r_state == S_IDLE) ? 1'b0 : r_pend | (key_req & w_busy);
         if (r_state == S_IDLE && w_accept) r_dec <= blk_dec;
         if (r_state == S_IDLE && w_req) begin
            key_ok  <= 1'b0;
            key_err <= 1'b0;
         end
         if (r_state == S_KEXP && w_next == S_KFIN) begin
            key_ok  <= kx_complete;
            key_err <= ~kx_complete;
         end
      end
   end

   sm4_key_store u_store (
      .i_clk   (sm4_ctrl_clk),
      .i_rst   (sm4_ctrl_rst),
      .i_we    (kx_en & (r_state == S_KEXP)),
      .i_waddr (kx_addr),
      .i_wdata (kx_rk),
      .i_re    (w_next == S_ROUND),
      .i_raddr (w_raddr),
      .o_rdata (rnd_key)
   );
endmodule

// File: tb/tb_sm4_ctrl.sv
// tb_sm4_ctrl: scenario tasks against a key-table/round-order reference model of sm4_ctrl.
module tb_sm4_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic key_req = 0, kx_en = 0, kx_complete = 0, blk_valid = 0, blk_dec = 0, done_ready = 0;
  logic [4:0] kx_addr = '0;
  logic [31:0] kx_rk = '0;
  logic key_ok, key_err, kx_begin, kx_hs, kx_last, blk_ready, rnd_start, rnd_en, done_valid;
  logic [4:0] rnd_idx;
  logic [31:0] rnd_key;
  logic [31:0] keys [32];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  sm4_ctrl dut (
    .sm4_ctrl_clk(clk), .sm4_ctrl_rst(rst), .key_req(key_req), .key_ok(key_ok), .key_err(key_err),
    .kx_begin(kx_begin), .kx_hs(kx_hs), .kx_last(kx_last), .kx_en(kx_en), .kx_addr(kx_addr),
    .kx_rk(kx_rk), .kx_complete(kx_complete), .blk_valid(blk_valid), .blk_dec(blk_dec),
    .blk_ready(blk_ready), .rnd_start(rnd_start), .rnd_en(rnd_en), .rnd_idx(rnd_idx),
    .rnd_key(rnd_key), .done_valid(done_valid), .done_ready(done_ready)
  );
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({key_ok, key_err, kx_begin, kx_hs, kx_last, blk_ready, rnd_start, rnd_en, done_valid, rnd_idx, rnd_key} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ok=%b err=%b beg=%b last=%b rdy=%b en=%b idx=%0d key=%h want all 0",
               key_ok, key_err, kx_begin, kx_last, blk_ready, rnd_en, rnd_idx, rnd_key);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic kexp_body(input bit fixed);
    logic [31:0] nk [32];
    foreach (nk[j]) nk[j] = $urandom;
    if (fixed) begin
      nk[0] = 32'hF12186F9;
      nk[31] = 32'h9124A012;
    end
    checks++;
    if (kx_begin !== 1 || kx_hs !== 1 || key_ok !== 0 || key_err !== 0) begin
      errors++;
      $display("FAIL kexp_start: got beg=%b hs=%b ok=%b err=%b want 1 1 0 0", kx_begin, kx_hs, key_ok, key_err);
    end
    for (int j = 0; j < 32; j++) begin
      kx_en = 1; kx_addr = 5'(j); kx_rk = nk[j];
      @(negedge clk);
      checks++;
      if (kx_begin !== 1 || blk_ready !== 0 || kx_last !== 0) begin
        errors++;
        $display("FAIL kexp_hold[%0d]: got beg=%b rdy=%b last=%b want 1 0 0", j, kx_begin, blk_ready, kx_last);
      end
    end
    kx_en = 0; kx_complete = 1;
    @(negedge clk);
    checks++;
    if (kx_last !== 1 || kx_begin !== 0 || key_ok !== 1 || key_err !== 0) begin
      errors++;
      $display("FAIL kfin: got last=%b beg=%b ok=%b err=%b want 1 0 1 0", kx_last, kx_begin, key_ok, key_err);
    end
    kx_complete = 0;
    @(negedge clk);
    checks++;
    if (kx_last !== 0 || blk_ready !== 1 || key_ok !== 1) begin
      errors++;
      $display("FAIL kexp_idle: got last=%b rdy=%b ok=%b want 0 1 1", kx_last, blk_ready, key_ok);
    end
    foreach (nk[j]) keys[j] = nk[j];
  endtask
  task automatic test_key_load(input bit fixed);
    key_req = 1;
    @(negedge clk);
    key_req = 0;
    kexp_body(fixed);
  endtask
  task automatic run_block(input bit dec, input int req_at);
    int unsigned wait_n;
    checks++;
    if (blk_ready !== 1) begin
      errors++;
      $display("FAIL blk_ready_idle: got %b want 1", blk_ready);
    end
    blk_valid = 1; blk_dec = dec;
    @(negedge clk);
    blk_valid = 0; blk_dec = 1'($urandom);
    checks++;
    if (rnd_start !== 1 || rnd_en !== 0) begin
      errors++;
      $display("FAIL rnd_start: got start=%b en=%b want 1 0", rnd_start, rnd_en);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      key_req = 0;
      checks++;
      if (rnd_en !== 1 || rnd_start !== 0 || rnd_idx !== 5'(i) || rnd_key !== keys[dec ? 31 - i : i]) begin
        errors++;
        $display("FAIL round[%0d] dec=%0d: got en=%b idx=%0d key=%h want en=1 idx=%0d key=%h",
                 i, dec, rnd_en, rnd_idx, rnd_key, i, keys[dec ? 31 - i : i]);
      end
      key_req = (i == req_at);
    end
    @(negedge clk);
    key_req = 0;
    wait_n = $urandom_range(0, 3);
    for (int w = 0; w <= int'(wait_n); w++) begin
      checks++;
      if (done_valid !== 1 || rnd_en !== 0) begin
        errors++;
        $display("FAIL done_valid: got dv=%b en=%b want 1 0", done_valid, rnd_en);
      end
      if (w == int'(wait_n)) done_ready = 1;
      @(negedge clk);
    end
    done_ready = 0;
    checks++;
    if (done_valid !== 0) begin
      errors++;
      $display("FAIL done_clear: got %b want 0", done_valid);
    end
  endtask
  task automatic test_ignore_kx_en;
    kx_en = 1; kx_addr = 5'd0; kx_rk = ~keys[0];
    @(negedge clk);
    kx_addr = 5'd31; kx_rk = ~keys[31];
    @(negedge clk);
    kx_en = 0;
    run_block(0, -1);
  endtask
  task automatic test_key_req_mid;
    run_block(0, 10);
    checks++;
    if (blk_ready !== 0 || key_ok !== 1 || kx_begin !== 0) begin
      errors++;
      $display("FAIL pending_idle: got rdy=%b ok=%b beg=%b want 0 1 0", blk_ready, key_ok, kx_begin);
    end
    blk_valid = 1;
    @(negedge clk);
    blk_valid = 0;
    kexp_body(0);
    run_block(1'($urandom), -1);
  endtask
  task automatic test_back_to_back;
    int starts[$];
    bit decq[$];
    bit cur = 0;
    blk_valid = 1; done_ready = 1;
    for (int c = 0; c < 200 && starts.size() < 4; c++) begin
      if (rnd_start === 1) starts.push_back(c);
      if (rnd_en === 1 && rnd_idx === 5'd0) begin
        cur = decq.size() > 0 ? decq.pop_front() : 1'b0;
        checks++;
        if (rnd_key !== keys[cur ? 31 : 0]) begin
          errors++;
          $display("FAIL b2b_first dec=%0d: got %h want %h", cur, rnd_key, keys[cur ? 31 : 0]);
        end
      end
      if (rnd_en === 1 && rnd_idx === 5'd31) begin
        checks++;
        if (rnd_key !== keys[cur ? 0 : 31]) begin
          errors++;
          $display("FAIL b2b_last dec=%0d: got %h want %h", cur, rnd_key, keys[cur ? 0 : 31]);
        end
      end
      blk_dec = 1'($urandom);
      if (blk_ready === 1) decq.push_back(blk_dec);
      @(negedge clk);
    end
    blk_valid = 0;
    checks++;
    if (starts.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d starts want 4", starts.size());
    end
    for (int k = 1; k < starts.size(); k++) begin
      checks++;
      if (starts[k] - starts[k-1] != 35) begin
        errors++;
        $display("FAIL b2b_period: got %0d cycles want 35", starts[k] - starts[k-1]);
      end
    end
    for (int c = 0; c < 60 && blk_ready !== 1; c++) @(negedge clk);
    done_ready = 0;
    checks++;
    if (blk_ready !== 1) begin
      errors++;
      $display("FAIL b2b_drain: got rdy=%b want 1", blk_ready);
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    key_req = 1;
    @(negedge clk);
    key_req = 0;
    while (kx_begin === 1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 64 || kx_last !== 1 || key_err !== 1 || key_ok !== 0) begin
      errors++;
      $display("FAIL timeout: got cycles=%0d last=%b err=%b ok=%b want 64 1 1 0", n, kx_last, key_err, key_ok);
    end
    @(negedge clk);
    checks++;
    if (kx_last !== 0 || blk_ready !== 0 || key_err !== 1) begin
      errors++;
      $display("FAIL timeout_idle: got last=%b rdy=%b err=%b want 0 0 1", kx_last, blk_ready, key_err);
    end
    test_key_load(0);
  endtask
  task automatic test_reset_mid;
    blk_valid = 1; blk_dec = 0;
    @(negedge clk);
    blk_valid = 0;
    for (int c = 0; c < 40 && !(rnd_en === 1 && rnd_idx === 5'd5); c++) @(negedge clk);
    checks++;
    if (rnd_idx !== 5'd5) begin
      errors++;
      $display("FAIL reset_mid_reach: got idx=%0d want 5", rnd_idx);
    end
    rst = 1;
    #1;
    checks++;
    if ({key_ok, key_err, kx_begin, kx_hs, kx_last, blk_ready, rnd_start, rnd_en, done_valid, rnd_idx, rnd_key} !== '0) begin
      errors++;
      $display("FAIL reset_async: got ok=%b en=%b idx=%0d key=%h dv=%b want all 0", key_ok, rnd_en, rnd_idx, rnd_key, done_valid);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (blk_ready !== 0 || key_ok !== 0 || rnd_en !== 0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b ok=%b en=%b want 0 0 0", blk_ready, key_ok, rnd_en);
    end
    test_key_load(1);
    run_block(1, -1);
  endtask
  initial begin
    test_reset;
    test_key_load(1);
    run_block(0, -1);
    run_block(1, -1);
    test_ignore_kx_en;
    test_key_req_mid;
    test_back_to_back;
    test_timeout;
    run_block(1'($urandom), -1);
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sm4_ctrl.md
# sm4_ctrl

Top-level sequencer for the SM4 core. It drives the key-expansion block through its begin/handshake protocol and captures the 32 round keys it emits into a local key store. It then runs one 32-round encrypt or decrypt pass per accepted data block, feeding the round datapath one round key per cycle: forward order for encryption, reverse order for decryption. It sits between the host-side block interface and the key-expansion and round-function datapaths.

## Interface
- ROUNDS, 32, rounds per block and key-store depth
- AW, 5, key-store address width
- KX_TIMEOUT, 64, maximum cycles from `kx_begin` rising to `kx_complete`
- sm4_ctrl_clk  in  1  clock, rising edge
- sm4_ctrl_rst  in  1  reset, asynchronous, active-high
- key_req  in  1  pulse: expand a new master key (MK is wired directly to the key expander)
- key_ok  out  1  round keys valid
- key_err  out  1  sticky: key-expansion timeout; cleared by next `key_req`
- kx_begin  out  1  to key expander `begin`
- kx_hs  out  1  to key expander `handshake`
- kx_last  out  1  to key expander `last`; one-cycle pulse that returns it to idle
- kx_en  in  1  round-key write strobe
- kx_addr  in  AW  round-key index
- kx_rk  in  32  round key
- kx_complete  in  1  expansion finished; level
- blk_valid  in  1  block request
- blk_dec  in  1  1 = decrypt, 0 = encrypt; sampled at accept
- blk_ready  out  1  block can be accepted
- rnd_start  out  1  one-cycle pulse: datapath loads the input block
- rnd_en  out  1  round-step enable
- rnd_idx  out  AW  round number 0..31
- rnd_key  out  32  round key for the current step
- done_valid  out  1  result available in the datapath
- done_ready  in  1  consumer takes the result

## Operation
- States:
  - IDLE
  - KEXP: expansion running
  - KFIN: pulse `kx_last`
  - LOAD: `rnd_start`
  - ROUND
  - DONE
- IDLE:
  - `key_req` -> KEXP. Clears `key_ok` and `key_err`, resets the timeout counter.
  - Otherwise, `blk_valid & blk_ready` -> LOAD. Latches `blk_dec`.
  - `key_req` has priority over a simultaneous `blk_valid`.
- `blk_ready` = (state == IDLE) & `key_ok` & ~`key_req`.
- KEXP:
  - `kx_begin` = `kx_hs` = 1 continuously.
  - Every cycle with `kx_en` = 1: key_store[`kx_addr`] <= `kx_rk`.
  - `kx_complete` -> KFIN; `key_ok` is set on that transition.
  - Timeout counter reaches KX_TIMEOUT -> KFIN with `key_err` = 1 and `key_ok` = 0.
- KFIN: `kx_begin` = `kx_hs` = 0, `kx_last` = 1 for one cycle -> IDLE.
- LOAD: `rnd_start` = 1; prefetch the key at address 0 (encrypt) or 31 (decrypt) -> ROUND.
- ROUND:
  - `rnd_en` = 1 for exactly 32 cycles.
  - `rnd_idx` counts 0..31.
  - `rnd_key` = key_store[i] when encrypting, key_store[31-i] when decrypting.
  - After `rnd_idx` = 31 -> DONE.
- DONE: `done_valid` = 1 until `done_ready`, then -> IDLE.
- `key_req` arriving in LOAD, ROUND or DONE:
  - Latched as pending; the current block completes with the old keys.
  - The pending request is served from IDLE next cycle; the block path is blocked meanwhile.
- `kx_en` outside KEXP is ignored; the key store is not written.
- Index arithmetic: unsigned AW-bit; the reverse address is `~i`, which requires ROUNDS = 2^AW.

## Timing
- All outputs are registered except `blk_ready`.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pending `key_req` cleared.
  - Key-store contents not reset; `key_ok` = 0 guards them.
- Reset mid-operation (any state): immediate return to IDLE.
  - The key expander sees `kx_begin` = 0; it falls back to idle through its own next-state logic.
- Block latency, with accept at edge 0:
  - `rnd_start` high in cycle 1.
  - `rnd_en` high in cycles 2..33; `rnd_key` and `rnd_idx` are valid in the same cycles.
  - `done_valid` rises in cycle 34.
  - Back-to-back throughput: 35 cycles per block when `done_ready` = 1.
- Key expansion:
  - `kx_begin` is held from the cycle after `key_req` until `kx_complete`.
  - `kx_last` follows `kx_complete` by exactly one cycle.
  - `key_ok` rises in the same cycle as `kx_last`.

## Structure
- Shared package `sm4_pkg` holds:
  - The state enum.
  - The ROUNDS, AW and KX_TIMEOUT defaults.
  - The round-key word type (32-bit).
- One sub-module, `sm4_key_store`: 32x32 register file with one synchronous write port (kx side) and one synchronous read port (rnd side), read data registered into `rnd_key`.
- FSM, round counter, timeout counter and pending flag live in `sm4_ctrl`.

## Test plan
- Key load: `key_req` with MK = 0123456789abcdeffedcba9876543210 -> `kx_begin` held; 32 writes captured; `kx_last` one-cycle pulse; `key_ok` = 1; store[0] = F12186F9, store[31] = 9124A012.
- Encrypt block (`blk_dec` = 0) -> `rnd_start` in cycle 1; `rnd_key` = F12186F9 at `rnd_idx` 0 and 9124A012 at `rnd_idx` 31; `done_valid` in cycle 34.
- Decrypt block (`blk_dec` = 1) -> `rnd_key` = 9124A012 at `rnd_idx` 0 and F12186F9 at `rnd_idx` 31.
- `key_req` at `rnd_idx` 10 -> remaining rounds use the old keys; after `done_ready`, `key_ok` drops, a new expansion runs and `blk_ready` stays 0 until it finishes.
- `kx_complete` never asserted -> after 64 cycles `key_err` = 1, `kx_last` pulses, `key_ok` = 0, `blk_ready` = 0.
- `sm4_ctrl_rst` asserted at `rnd_idx` 5 -> all outputs 0 asynchronously; `key_ok` = 0; state IDLE after release.
